// File: rtl/dmem_store_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_store_ctrl_pkg
//   Shared definitions for the store-side data-memory controller:
//   - store opcode encodings (ST_SB .. ST_SWR)
//   - bus transfer size encodings
//   - drain FSM state enum
//   - store-buffer entry layout
// -----------------------------------------------------------------------------
package dmem_store_ctrl_pkg;

    // Store opcodes presented on st_op. Codes 5-7 are reserved.
    localparam logic [2:0] ST_SB  = 3'd0;
    localparam logic [2:0] ST_SH  = 3'd1;
    localparam logic [2:0] ST_SW  = 3'd2;
    localparam logic [2:0] ST_SWL = 3'd3;
    localparam logic [2:0] ST_SWR = 3'd4;

    // Bus transfer size (data_size).
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Drain FSM: one buffered store per IDLE -> REQ -> (WAIT) -> IDLE pass.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // One store-buffer entry: everything the bus needs for a single write.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sb_entry_t;

    // Reserved opcodes are accepted but never enqueued.
    function automatic logic op_is_store(input logic [2:0] op);
        return op <= ST_SWR;
    endfunction

endpackage

// File: rtl/dmem_store_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_store_ctrl_if
//   Write channel of the data-SRAM-like bus.
//   master (store controller): drives data_req/wr/size/addr/wstrb/wdata,
//                              receives data_addr_ok/data_ok.
//   slave  (memory side)     : the reverse.
// -----------------------------------------------------------------------------
interface dmem_store_ctrl_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_ok
    );

endinterface

// File: rtl/dmem_store_ctrl_store_lane_fmt.sv
// -----------------------------------------------------------------------------
// store_lane_fmt
//   Purely combinational store formatter. Turns a MEM-stage store request
//   into the bus view of that store (byte strobes, lane-replicated or shifted
//   data, transfer size, bus address) and flags misaligned SH/SW.
//   Ports:
//     op    in   store opcode (ST_SB..ST_SWR, 5-7 reserved)
//     addr  in   byte address
//     data  in   raw rt register value
//     entry out  formatted {addr, size, wstrb, wdata}
//     ades  out  misaligned SH (addr[0]) or SW (addr[1:0] != 0)
// -----------------------------------------------------------------------------
module store_lane_fmt
    import dmem_store_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output sb_entry_t   entry,
    output logic        ades
);

    logic [1:0] a;
    logic [1:0] a_inv;

    assign a     = addr[1:0];
    assign a_inv = ~a;          // 3 - a for a 2-bit offset

    always_comb begin
        // NOTE: every output gets a default before the case so that no
        // path leaves a value unassigned, which would infer a latch.
        entry.addr  = addr;
        entry.size  = SIZE_WORD;
        entry.wstrb = 4'b0000;
        entry.wdata = data;
        ades        = 1'b0;

        unique case (op)
            ST_SB: begin
                entry.size  = SIZE_BYTE;
                entry.wstrb = 4'b0001 << a;
                entry.wdata = {4{data[7:0]}};
            end
            ST_SH: begin
                entry.size  = SIZE_HALF;
                entry.wstrb = a[1] ? 4'b1100 : 4'b0011;
                entry.wdata = {2{data[15:0]}};
                ades        = a[0];
            end
            ST_SW: begin
                entry.wstrb = 4'b1111;
                ades        = (a != 2'b00);
            end
            ST_SWL: begin
                // Most-significant bytes of rt land in the low lanes up to a.
                entry.addr  = {addr[31:2], 2'b00};
                entry.wdata = data >> {a_inv, 3'b000};
                unique case (a)
                    2'd0:    entry.wstrb = 4'b0001;
                    2'd1:    entry.wstrb = 4'b0011;
                    2'd2:    entry.wstrb = 4'b0111;
                    default: entry.wstrb = 4'b1111;
                endcase
            end
            ST_SWR: begin
                // Least-significant bytes of rt land in lanes a and above.
                entry.addr  = {addr[31:2], 2'b00};
                entry.wdata = data << {a, 3'b000};
                entry.wstrb = 4'b1111 << a;
            end
            default: ;  // reserved opcodes: defaults, never enqueued
        endcase
    end

endmodule

// File: rtl/dmem_store_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_store_ctrl
//   Store-side controller between the MEM stage and the data bus.
//   Formats stores at enqueue, keeps them in an in-order buffer of DEPTH
//   entries and drains them one at a time over the req/addr_ok/data_ok
//   handshake. The head entry stays valid until data_ok, so the load-path
//   hazard check also covers the store that is currently on the bus.
//   Ports:
//     clk, resetn         clock, asynchronous active-low reset
//     st_valid/st_ready   store request handshake from MEM
//     st_op/addr/data     store opcode, byte address, raw rt value
//     st_ades             combinational misaligned SH/SW flag
//     ld_addr/ld_hit      word-address hazard probe from the load path
//     sb_empty            buffer empty and drain FSM idle
//     bus                 write channel (master modport)
//   DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module dmem_store_ctrl
    import dmem_store_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [2:0]           st_op,
    input  logic [31:0]          st_addr,
    input  logic [31:0]          st_data,
    output logic                 st_ades,
    input  logic [31:0]          ld_addr,
    output logic                 ld_hit,
    output logic                 sb_empty,
    dmem_store_ctrl_if.master    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [DEPTH-1:0]    valid_q;
    sb_entry_t           mem_q [DEPTH];

    sb_entry_t           fmt_entry;
    logic                fmt_ades;
    logic                push;
    logic                pop;
    logic                hit;
    logic                unused_ok;

    // ------------------------------------------------------------------
    // Enqueue path
    // ------------------------------------------------------------------
    store_lane_fmt u_fmt (
        .op    (st_op),
        .addr  (st_addr),
        .data  (st_data),
        .entry (fmt_entry),
        .ades  (fmt_ades)
    );

    // Ready depends only on occupancy, never on a same-cycle pop, so the
    // MEM stage never sees a combinational path from the bus handshake.
    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign st_ades  = st_valid && fmt_ades;

    // Misaligned and reserved requests still complete the handshake.
    assign push = st_valid && st_ready && !fmt_ades && op_is_store(st_op);

    // ------------------------------------------------------------------
    // Drain FSM, next-state and pop decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_ok) begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.data_ok) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q <= state_d;

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            // With a pop pending count > 0, and with a push pending
            // count < DEPTH, so the two slots never coincide.
            if (pop)  valid_q[rd_ptr_q] <= 1'b0;
            if (push) valid_q[wr_ptr_q] <= 1'b1;

            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the entry payload has no reset; valid_q and count_q gate every
    // use of it, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fmt_entry;
    end

    // ------------------------------------------------------------------
    // Bus outputs: always the head entry, held stable while it is pending
    // because rd_ptr only moves on pop.
    // ------------------------------------------------------------------
    assign bus.data_req   = (state_q == S_REQ);
    assign bus.data_wr    = 1'b1;
    assign bus.data_size  = mem_q[rd_ptr_q].size;
    assign bus.data_addr  = mem_q[rd_ptr_q].addr;
    assign bus.data_wstrb = mem_q[rd_ptr_q].wstrb;
    assign bus.data_wdata = mem_q[rd_ptr_q].wdata;

    // ------------------------------------------------------------------
    // Status to the load path and sync/eret logic
    // ------------------------------------------------------------------
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].addr[31:2] == ld_addr[31:2])) hit = 1'b1;
        end
    end

    assign ld_hit   = hit;
    assign sb_empty = (valid_q == '0) && (state_q == S_IDLE);

    // The hazard check is word-granular; the byte offset is irrelevant.
    assign unused_ok = &{1'b0, ld_addr[1:0]};

endmodule

// File: tb/tb_dmem_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_store_ctrl
//   Scoreboard bench: every accepted store pushes its expected bus beat
//   (from an independent byte-loop model) onto exp_q; a bus responder pops
//   and compares when the controller raises data_req, then completes the
//   handshake with programmable addr_ok/data_ok timing.
// -----------------------------------------------------------------------------
module tb_dmem_store_ctrl;
    import dmem_store_ctrl_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [2:0]  st_op = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ades;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        sb_empty;

    dmem_store_ctrl_if bus ();

    dmem_store_ctrl #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_op    (st_op),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ades  (st_ades),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .sb_empty (sb_empty),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    txn_t exp_q[$];

    int   addr_dly  = 0;
    int   data_dly  = 0;
    bit   same_cyc  = 1'b0;
    int   pops      = 0;
    bit   resp_busy = 1'b0;
    bit   in_wait   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference formatter written per byte lane.
    function automatic txn_t model(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] d);
        txn_t t;
        int   a;
        a       = int'(addr[1:0]);
        t.addr  = addr;
        t.size  = 2'd2;
        t.wstrb = 4'b0000;
        t.wdata = 32'h0;
        case (op)
            3'd0: begin
                t.size     = 2'd0;
                t.wstrb[a] = 1'b1;
                for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = d[7:0];
            end
            3'd1: begin
                t.size = 2'd1;
                for (int i = 0; i < 4; i++) if ((i / 2) == (a / 2)) t.wstrb[i] = 1'b1;
                t.wdata = {d[15:0], d[15:0]};
            end
            3'd2: begin
                t.wstrb = 4'b1111;
                t.wdata = d;
            end
            3'd3: begin
                t.addr = {addr[31:2], 2'b00};
                for (int i = 0; i < 4; i++) if (i <= a) begin
                    t.wstrb[i]        = 1'b1;
                    t.wdata[8*i +: 8] = d[8*(i + 3 - a) +: 8];
                end
            end
            default: begin
                t.addr = {addr[31:2], 2'b00};
                for (int i = 0; i < 4; i++) if (i >= a) begin
                    t.wstrb[i]        = 1'b1;
                    t.wdata[8*i +: 8] = d[8*(i - a) +: 8];
                end
            end
        endcase
        return t;
    endfunction

    function automatic bit model_ades(input logic [2:0] op, input logic [31:0] addr);
        return (op == 3'd1 && addr[0]) || (op == 3'd2 && addr[1:0] != 2'b00);
    endfunction

    // Called at posedge+1; returns at posedge+1 right after acceptance so
    // consecutive calls drive back-to-back requests.
    task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d,
                            output int waited, output bit just_popped);
        int prev_pops;
        waited      = 0;
        just_popped = 1'b0;
        prev_pops   = pops;
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = d;
        forever begin
            @(negedge clk);
            if (st_ready) break;
            prev_pops = pops;
            waited++;
            if (waited > 200) begin
                check("st_ready_timeout", 32'd0, 32'd1);
                @(posedge clk); #1 st_valid = 1'b0;
                return;
            end
        end
        just_popped = (pops != prev_pops);
        check("st_ades", st_ades, model_ades(op, addr));
        @(posedge clk);
        if (!model_ades(op, addr) && op <= 3'd4) exp_q.push_back(model(op, addr, d));
        #1 st_valid = 1'b0;
    endtask

    task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        int w;
        bit p;
        do_store(op, addr, d, w, p);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(exp_q.size() == 0 && sb_empty && !resp_busy)) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Bus responder / scoreboard consumer.
    initial begin
        txn_t t;
        int   a_d;
        int   d_d;
        bit   sc;
        bus.data_addr_ok = 1'b0;
        bus.data_ok      = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && bus.data_req) begin
                resp_busy = 1'b1;
                a_d = addr_dly;
                d_d = data_dly;
                sc  = same_cyc;
                if (exp_q.size() == 0) begin
                    check("req_unexpected", 32'd1, 32'd0);
                    t = '{addr: bus.data_addr, size: bus.data_size,
                          wstrb: bus.data_wstrb, wdata: bus.data_wdata};
                end else begin
                    t = exp_q.pop_front();
                end
                check("bus_addr",  bus.data_addr,  t.addr);
                check("bus_size",  32'(bus.data_size),  32'(t.size));
                check("bus_wstrb", 32'(bus.data_wstrb), 32'(t.wstrb));
                check("bus_wdata", bus.data_wdata, t.wdata);
                check("bus_wr",    32'(bus.data_wr), 32'd1);
                for (int k = 0; k < a_d; k++) begin
                    @(negedge clk);
                    check("req_held",  32'(bus.data_req), 32'd1);
                    check("addr_held", bus.data_addr, t.addr);
                end
                bus.data_addr_ok = 1'b1;
                bus.data_ok      = sc;
                @(posedge clk);
                if (sc) pops++;
                #1;
                bus.data_addr_ok = 1'b0;
                bus.data_ok      = 1'b0;
                if (sc) begin
                    @(negedge clk);
                    check("idle_after_same_cycle", 32'(bus.data_req), 32'd0);
                end else begin
                    in_wait = 1'b1;
                    for (int k = 0; k <= d_d; k++) begin
                        @(negedge clk);
                        check("wait_req_low", 32'(bus.data_req), 32'd0);
                    end
                    bus.data_ok = 1'b1;
                    @(posedge clk);
                    pops++;
                    #1 bus.data_ok = 1'b0;
                    in_wait = 1'b0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        bit          p;
        int          pops0;
        int          n;
        logic [31:0] ra;
        logic [31:0] rd;
        logic [2:0]  rop;

        // Reset state
        #1;
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_data_req", 32'(bus.data_req), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_ld_hit",   32'(ld_hit), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 32'(sb_empty), 32'd1);
        @(posedge clk); #1;

        // Lane formatting vectors
        store(ST_SWL, 32'h1000_0001, 32'hAABB_CCDD);
        wait_drain();
        store(ST_SWR, 32'h1000_0002, 32'hAABB_CCDD);
        wait_drain();
        store(ST_SB,  32'h0000_0003, 32'h0000_005A);
        wait_drain();
        store(ST_SH,  32'h0000_0102, 32'h1234_BEEF);
        wait_drain();
        store(ST_SW,  32'h0000_0200, 32'hCAFE_F00D);
        wait_drain();

        // Misaligned and reserved requests: accepted, nothing enqueued.
        store(ST_SH, 32'h1000_0011, 32'h1111_2222);
        store(ST_SW, 32'h1000_0012, 32'h3333_4444);
        store(3'd5,  32'h1000_0020, 32'h5555_6666);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ades_sb_empty", 32'(sb_empty), 32'd1);
            check("ades_no_req",   32'(bus.data_req), 32'd0);
        end
        @(posedge clk); #1;

        // Three stores back to back, DEPTH=2, addr_ok after 3 cycles.
        addr_dly = 3;
        data_dly = 0;
        pops0    = pops;
        do_store(ST_SW, 32'h0000_3000, 32'h0000_0001, w, p);
        check("bb1_wait", w, 0);
        do_store(ST_SW, 32'h0000_3004, 32'h0000_0002, w, p);
        check("bb2_wait", w, 0);
        do_store(ST_SW, 32'h0000_3008, 32'h0000_0003, w, p);
        check("bb3_stalled",    32'(w > 0), 32'd1);
        check("bb3_after_pop",  32'(p), 32'd1);
        check("bb3_pops_before", pops - pops0, 1);
        wait_drain();
        check("bb_pops_total", pops - pops0, 3);

        // ld_hit on the in-flight store until data_ok.
        addr_dly = 0;
        data_dly = 4;
        ld_addr  = 32'h0000_2007;
        store(ST_SW, 32'h0000_2004, 32'h7777_8888);
        n = 0;
        forever begin
            @(negedge clk); #1;
            check("ld_hit_inflight", 32'(ld_hit), 32'd1);
            if (bus.data_ok) break;
            n++;
            if (n > 50) begin
                check("ld_hit_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk); #1;
        check("ld_hit_cleared", 32'(ld_hit), 32'd0);
        wait_drain();

        ld_addr = 32'h0000_2008;
        store(ST_SW, 32'h0000_2004, 32'h9999_AAAA);
        n = 0;
        forever begin
            @(negedge clk); #1;
            check("ld_miss_next_word", 32'(ld_hit), 32'd0);
            if (bus.data_ok) break;
            n++;
            if (n > 50) begin
                check("ld_miss_timeout", 32'd0, 32'd1);
                break;
            end
        end
        wait_drain();

        // addr_ok and data_ok together: single pop, IDLE next cycle.
        same_cyc = 1'b1;
        pops0    = pops;
        store(ST_SB, 32'h0000_4001, 32'h0000_00C3);
        wait_drain();
        check("same_cycle_one_pop", pops - pops0, 1);
        check("same_cycle_empty",   32'(sb_empty), 32'd1);

        // Random mix with random handshake timing.
        for (int i = 0; i < 16; i++) begin
            rop      = 3'($urandom_range(0, 4));
            ra       = 32'h4000_0000 | ($urandom() & 32'h0000_FFFF);
            rd       = $urandom();
            addr_dly = $urandom_range(0, 3);
            data_dly = $urandom_range(0, 2);
            same_cyc = 1'($urandom_range(0, 1));
            store(rop, ra, rd);
        end
        wait_drain();
        same_cyc = 1'b0;

        // Asynchronous reset while a store is in WAIT.
        addr_dly = 0;
        data_dly = 10;
        ld_addr  = 32'h0000_5000;
        store(ST_SW, 32'h0000_5000, 32'h0BAD_0BAD);
        n = 0;
        while (!in_wait && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 32'(in_wait), 32'd1);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        check("rst_wait_req",      32'(bus.data_req), 32'd0);
        check("rst_wait_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_wait_ld_hit",   32'(ld_hit), 32'd0);
        check("rst_wait_ready",    32'(st_ready), 32'd1);
        @(posedge clk); #1 resetn = 1'b1;
        n = 0;
        while (resp_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("responder_idle", 32'(resp_busy), 32'd0);
        @(posedge clk); #1;

        // Recovery after reset.
        data_dly = 0;
        store(ST_SB, 32'h0000_6002, 32'h0000_0081);
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
